j1_uart_loader: RTL and testbench

Serial boot loader for the J1 core. It receives a framed program image over an 8N1 UART line, assembles big-endian 16-bit words, and writes them into the core's instruction memory through the program interface (`pgm_addr`, `pgm_data`, `pgm_we`). It holds the CPU in reset while loading, validates a 16-bit XOR checksum, and releases the CPU only after a good image has loaded.

---
 rtl/j1_uart_loader.sv | 180 ++++++++++++++++++
 tb/tb_j1_uart_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/j1_uart_loader.sv
// rtl/j1_uart_loader.sv - UART boot loader writing a checksummed program image into J1 instruction memory
module j1_uart_loader #(
    parameter int DIVISOR       = 434,
    parameter int TIMEOUT_BITS  = 1024,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        uart_rx_i,
    output logic [15:0] pgm_addr,
    output logic [15:0] pgm_data,
    output logic        pgm_we,
    output logic        cpu_rst_o,
    output logic        load_busy_o,
    output logic        load_done_o,
    output logic        load_err_o
);
    localparam int CW   = $clog2(DIVISOR);
    localparam int TLIM = TIMEOUT_BITS * DIVISOR;
    localparam int TW   = $clog2(TLIM + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_SUM_H, S_SUM_L} state_t;

    logic            rx_s1, rx_s2, rx_s3;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            byte_v, frm_err;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            byte_v   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx_i};
            byte_v  <= 1'b0;
            frm_err <= 1'b0;
            case (rx_state)
                R_IDLE: if (rx_s3 && !rx_s2) begin
                    rx_state <= R_START;
                    rx_cnt   <= '0;
                end
                R_START: if (rx_cnt == CW'(DIVISOR / 2 - 1)) begin
                    // line back high at mid start bit means a glitch, not a character
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                R_DATA: if (rx_cnt == CW'(DIVISOR - 1)) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= R_STOP;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                default: if (rx_cnt == CW'(DIVISOR - 1)) begin
                    rx_cnt   <= '0;
                    rx_state <= R_IDLE;
                    byte_v   <= rx_s2;
                    frm_err  <= !rx_s2;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            endcase
        end
    end

    state_t        state, state_n;
    logic [7:0]    hi_byte;
    logic [15:0]   n_words, word_cnt, next_addr, acc;
    logic [TW-1:0] tmr;
    logic [15:0]   word;
    logic          abort_ev, oversize, last_word, sum_ok;
    logic          do_start, do_write, do_done, do_err;

    // hi_byte always holds the previous byte, so word is the pair just completed
    assign word      = {hi_byte, rx_shift};
    assign abort_ev  = (state != S_IDLE) && (frm_err || tmr == TW'(TLIM - 1));
    assign oversize  = word > 16'd8192;
    assign last_word = (word_cnt + 16'd1) == n_words;
    assign sum_ok    = word == acc;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state <= S_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort_ev) begin
            state_n = S_IDLE;
        end else if (byte_v) begin
            case (state)
                S_IDLE:  if (rx_shift == 8'h55) state_n = S_CNT_H;
                S_CNT_H: state_n = S_CNT_L;
                S_CNT_L: state_n = oversize ? S_IDLE : (word == 16'd0 ? S_SUM_H : S_DAT_H);
                S_DAT_H: state_n = S_DAT_L;
                S_DAT_L: state_n = last_word ? S_SUM_H : S_DAT_H;
                S_SUM_H: state_n = S_SUM_L;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        do_start = 1'b0;
        do_write = 1'b0;
        do_done  = 1'b0;
        do_err   = abort_ev;
        if (!abort_ev && byte_v) begin
            case (state)
                S_IDLE:  do_start = rx_shift == 8'h55;
                S_CNT_L: do_err   = oversize;
                S_DAT_L: do_write = 1'b1;
                S_SUM_L: begin
                    do_done = sum_ok;
                    do_err  = !sum_ok;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            hi_byte     <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            next_addr   <= '0;
            acc         <= '0;
            tmr         <= '0;
            pgm_addr    <= '0;
            pgm_data    <= '0;
            pgm_we      <= 1'b0;
            cpu_rst_o   <= HOLD_AT_RESET;
            load_busy_o <= 1'b0;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
        end else begin
            pgm_we      <= do_write;
            load_busy_o <= state_n != S_IDLE;
            tmr         <= (state == S_IDLE || byte_v) ? '0 : tmr + TW'(1);
            if (byte_v) hi_byte <= rx_shift;
            if (state == S_CNT_L && byte_v) n_words <= word;
            if (do_start) begin
                cpu_rst_o   <= 1'b1;
                load_done_o <= 1'b0;
                load_err_o  <= 1'b0;
                word_cnt    <= '0;
                next_addr   <= '0;
                acc         <= '0;
            end
            if (do_write) begin
                pgm_addr  <= next_addr;
                pgm_data  <= word;
                next_addr <= next_addr + 16'd2;
                word_cnt  <= word_cnt + 16'd1;
                acc       <= acc ^ word;
            end
            if (do_done) begin
                load_done_o <= 1'b1;
                cpu_rst_o   <= 1'b0;
            end
            if (do_err) begin
                load_err_o <= 1'b1;
                cpu_rst_o  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_j1_uart_loader.sv
// tb/tb_j1_uart_loader.sv - directed bench for j1_uart_loader with DIVISOR=16, TIMEOUT_BITS=32
module tb_j1_uart_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] pgm_addr, pgm_data;
    logic        pgm_we, cpu_rst, busy, done, err;

    always #5 clk = ~clk;

    j1_uart_loader #(.DIVISOR(16), .TIMEOUT_BITS(32), .HOLD_AT_RESET(1'b0)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx_i(rx),
        .pgm_addr(pgm_addr), .pgm_data(pgm_data), .pgm_we(pgm_we),
        .cpu_rst_o(cpu_rst), .load_busy_o(busy), .load_done_o(done), .load_err_o(err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  frame[$];
    int rst_bad = 0;
    int we_run  = 0;
    int we_long = 0;

    always @(negedge clk) begin
        if (pgm_we) begin
            wr_addr.push_back(pgm_addr);
            wr_data.push_back(pgm_data);
            if (!cpu_rst) rst_bad++;
            we_run++;
            if (we_run > 1) we_long++;
        end else begin
            we_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (16) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(posedge clk); #1;
        end
        rx = stop;
        repeat (16) @(posedge clk); #1;
        rx = 1'b1;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_three_writes(input string tag);
        check({tag, "_nwr"}, wr_addr.size(), 3);
        check({tag, "_a0"}, wr_addr[0], 16'h0000);
        check({tag, "_d0"}, wr_data[0], 16'h1234);
        check({tag, "_a1"}, wr_addr[1], 16'h0002);
        check({tag, "_d1"}, wr_data[1], 16'hABCD);
        check({tag, "_a2"}, wr_addr[2], 16'h0004);
        check({tag, "_d2"}, wr_data[2], 16'h0001);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst_addr", pgm_addr, 0);
        check("rst_data", pgm_data, 0);
        check("rst_we", pgm_we, 0);
        check("rst_cpu", cpu_rst, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // good load, watching cpu_rst rise right after the magic byte
        clear_writes();
        send_byte(8'h55, 1'b1);
        repeat (2) @(posedge clk); #1;
        check("magic_cpu", cpu_rst, 1);
        check("magic_busy", busy, 1);
        frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hB9, 8'hF8};
        send_frame();
        check_three_writes("good");
        check("good_cpu", cpu_rst, 0);
        check("good_done", done, 1);
        check("good_err", err, 0);
        check("good_busy", busy, 0);

        clear_writes();
        frame = '{8'h55, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hB9, 8'hF9};
        send_frame();
        check_three_writes("badsum");
        check("badsum_cpu", cpu_rst, 1);
        check("badsum_done", done, 0);
        check("badsum_err", err, 1);

        clear_writes();
        frame = '{8'h00, 8'hFF, 8'hAA};
        send_frame();
        check("noise_nwr", wr_addr.size(), 0);
        check("noise_busy", busy, 0);
        check("noise_err", err, 1);
        check("noise_cpu", cpu_rst, 1);
        frame = '{8'h55, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hB9, 8'hF8};
        send_frame();
        check_three_writes("noise");
        check("noise_done", done, 1);
        check("noise_cpu2", cpu_rst, 0);

        clear_writes();
        frame = '{8'h55, 8'h20, 8'h01};
        send_frame();
        check("over_nwr", wr_addr.size(), 0);
        check("over_err", err, 1);
        check("over_busy", busy, 0);
        check("over_cpu", cpu_rst, 1);
        frame = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame();
        check("empty_done", done, 1);
        check("empty_err", err, 0);
        check("empty_cpu", cpu_rst, 0);

        // the last byte_v lands a few clocks before send_byte returns
        clear_writes();
        frame = '{8'h55, 8'h00, 8'h02};
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (490) @(posedge clk); #1;
        check("tmo_early_err", err, 0);
        check("tmo_early_busy", busy, 1);
        repeat (40) @(posedge clk); #1;
        check("tmo_err", err, 1);
        check("tmo_cpu", cpu_rst, 1);
        check("tmo_busy", busy, 0);
        check("tmo_nwr", wr_addr.size(), 0);

        foreach (frame[i]) send_byte(frame[i], 1'b1);
        check("frm_pre_err", err, 0);
        send_byte(8'h12, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("frm_err", err, 1);
        check("frm_cpu", cpu_rst, 1);
        check("frm_busy", busy, 0);
        check("frm_nwr", wr_addr.size(), 0);

        clear_writes();
        frame = '{8'h55, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD};
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (3) @(posedge clk); #1;
        check("mid_nwr", wr_addr.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_we", pgm_we, 0);
        check("mid_cpu", cpu_rst, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        check("mid_addr", pgm_addr, 0);

        rx = 1'b0;
        repeat (2) @(posedge clk); #1;
        rx = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("glitch_busy", busy, 0);
        frame = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame();
        check("glitch_done", done, 1);
        check("glitch_err", err, 0);
        check("glitch_nwr", wr_addr.size(), 2);

        check("we_cpu_rst", rst_bad, 0);
        check("we_width", we_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
